rv32im_dmem_responder: RTL

//  Data-memory responder at the far end of the EXU load/store interface. It accepts one
//  LSU request at a time (opcode, address, store data) and performs the access on an

---
 rtl/rv32im_dmem_responder.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32im_dmem_responder.sv
// rv32im_dmem_responder
//   Data-memory responder sitting at the far end of the EXU load/store interface.
//   Takes one LSU request at a time, waits WAIT_STATES cycles, then performs
//   the access on an internal word-organised RAM and returns one response strobe
//   carrying either extended load data or an error flag.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   req_valid_i      LSU request present
//   req_ready_o      responder can accept a request (high only in IDLE)
//   lsu_opcode_i     NONE/LB/LH/LW/LBU/LHU/SB/SH/SW
//   val_memaddr_i    byte address
//   val_memdatawr_i  store data, right-aligned
//   val_memdatard_o  load result extended to 32 bits (held until next response)
//   rsp_valid_o      one-cycle response strobe
//   rsp_err_o        response is an error (misaligned or out of range)

`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`define LSU_OPCODE_NONE  4'd0
`define LSU_OPCODE_LB    4'd1
`define LSU_OPCODE_LH    4'd2
`define LSU_OPCODE_LW    4'd3
`define LSU_OPCODE_LBU   4'd4
`define LSU_OPCODE_LHU   4'd5
`define LSU_OPCODE_SB    4'd6
`define LSU_OPCODE_SH    4'd7
`define LSU_OPCODE_SW    4'd8
`endif

`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

module rv32im_dmem_responder #(
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_STATES     = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [`LSU_OPCODE_WIDTH-1:0]  lsu_opcode_i,
    input  logic [`API_DATA_WIDTH-1:0]    val_memaddr_i,
    input  logic [`API_DATA_WIDTH-1:0]    val_memdatawr_i,
    output logic [`API_DATA_WIDTH-1:0]    val_memdatard_o,
    output logic                          rsp_valid_o,
    output logic                          rsp_err_o
);

    localparam int OPW = `LSU_OPCODE_WIDTH;
    localparam int DW  = `API_DATA_WIDTH;
    localparam int AW  = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [DW:0] BYTE_LIMIT = (DW + 1)'(4 * MEM_DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [DW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             ready_q, ready_d;

    logic [DW-1:0]    mem [MEM_DEPTH_WORDS];

    logic             accept;
    logic             from_idle;
    logic             commit;
    logic [OPW-1:0]   acc_op;
    logic [DW-1:0]    acc_addr;
    logic [DW-1:0]    acc_wdata;
    logic [AW-1:0]    word_idx;
    logic [DW-1:0]    rd_word;
    logic             is_load, is_store, is_half, is_word;
    logic             misalign, out_of_range, acc_err;
    logic [3:0]       st_be;
    logic [DW-1:0]    st_data;
    logic             mem_we;

    // Byte/half selection from the little-endian word plus sign/zero extension.
    function automatic logic [DW-1:0] load_extract(
        input logic [OPW-1:0] op,
        input logic [DW-1:0]  w,
        input logic [1:0]     off
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            `LSU_OPCODE_LB:  load_extract = {{24{b[7]}}, b};
            `LSU_OPCODE_LBU: load_extract = {24'd0, b};
            `LSU_OPCODE_LH:  load_extract = {{16{h[15]}}, h};
            `LSU_OPCODE_LHU: load_extract = {16'd0, h};
            `LSU_OPCODE_LW:  load_extract = w;
            default:         load_extract = '0;
        endcase
    endfunction

    // Byte-lane enables for a store at the given offset.
    function automatic logic [3:0] store_lanes(
        input logic [OPW-1:0] op,
        input logic [1:0]     off
    );
        case (op)
            `LSU_OPCODE_SB: store_lanes = 4'b0001 << off;
            `LSU_OPCODE_SH: store_lanes = off[1] ? 4'b1100 : 4'b0011;
            `LSU_OPCODE_SW: store_lanes = 4'b1111;
            default:        store_lanes = 4'b0000;
        endcase
    endfunction

    // Replicate the right-aligned store data across all lanes; the enables pick.
    function automatic logic [DW-1:0] store_replicate(
        input logic [OPW-1:0] op,
        input logic [DW-1:0]  d
    );
        case (op)
            `LSU_OPCODE_SB: store_replicate = {4{d[7:0]}};
            `LSU_OPCODE_SH: store_replicate = {2{d[15:0]}};
            default:        store_replicate = d;
        endcase
    endfunction

    assign accept    = req_valid_i && ready_q;
    assign from_idle = (state_q == S_IDLE);

    // With zero wait states the access commits on the accept edge itself, so
    // the operands come straight from the ports instead of the latches.
    assign acc_op    = from_idle ? lsu_opcode_i    : op_q;
    assign acc_addr  = from_idle ? val_memaddr_i   : addr_q;
    assign acc_wdata = from_idle ? val_memdatawr_i : wdata_q;

    assign commit = (from_idle && accept && (WAIT_STATES == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd0));

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (acc_op)
            `LSU_OPCODE_LB, `LSU_OPCODE_LBU: is_load = 1'b1;
            `LSU_OPCODE_LH, `LSU_OPCODE_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            `LSU_OPCODE_LW:                  begin is_load  = 1'b1; is_word = 1'b1; end
            `LSU_OPCODE_SB:                  is_store = 1'b1;
            `LSU_OPCODE_SH:                  begin is_store = 1'b1; is_half = 1'b1; end
            `LSU_OPCODE_SW:                  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign misalign     = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
    assign out_of_range = ({1'b0, acc_addr} >= BYTE_LIMIT);
    // NONE (and unknown encodings) never touch the RAM, so they never fault.
    assign acc_err      = (is_load || is_store) && (misalign || out_of_range);

    assign word_idx = acc_addr[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign st_be    = store_lanes(acc_op, acc_addr[1:0]);
    assign st_data  = store_replicate(acc_op, acc_wdata);
    assign mem_we   = commit && is_store && !acc_err && !rst_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = lsu_opcode_i;
                    addr_d  = val_memaddr_i;
                    wdata_d = val_memdatawr_i;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            err_d   = acc_err;
            rdata_d = (is_load && !acc_err) ? load_extract(acc_op, rd_word, acc_addr[1:0]) : '0;
        end

        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // Control/state boundary: everything the FSM owns, cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            op_q        <= `LSU_OPCODE_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
        end
    end

    // RAM boundary: contents survive reset; only enabled byte lanes are written.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    assign req_ready_o     = ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_err_o       = err_q;
    assign val_memdatard_o = rdata_q;

endmodule
